add_seq: RTL
============

// Module: add_seq
// PURPOSE
//   Parametrised multi-cycle adder/subtractor, the successor of the 4-bit combinational add.
//   Computes a+b+cin or a-b over WIDTH bits, CHUNK bits per clock, LSB chunk first.
//   Uses a start/busy/done handshake so wide datapaths reuse one narrow carry chain.
//   Sits in the ArithmeticOps group; consumed by the ALU sequencer.
// PARAMETERS
//   WIDTH  32  operand/result width in bits; must be a multiple of CHUNK
//   CHUNK   8  bits added per cycle; NCHUNK = WIDTH/CHUNK (>=1)
// PORTS
//   clk       in   1      rising-edge clock
//   rst       in   1      asynchronous, active-high reset
//   start     in   1      request; sampled only in IDLE or DONE
//   sub       in   1      0: a+b+cin, 1: a-b (cin ignored)
//   a         in   WIDTH  operand A, latched on accepted start
//   b         in   WIDTH  operand B, latched on accepted start
//   cin       in   1      carry in (add mode only), latched on accepted start
//   busy      out  1      high while state==BUSY
//   done      out  1      one-cycle pulse, high while state==DONE
//   sum       out  WIDTH  result; holds until the next completion
//   cout      out  1      carry out of MSB (sub mode: 1 = no borrow)
//   overflow  out  1      signed overflow = carry into MSB XOR carry out of MSB
// BEHAVIOUR
//   - Reset (async, any time incl. mid-operation): state=IDLE, chunk index=0,
//     busy=0, done=0, sum=0, cout=0, overflow=0; latched operands discarded.
//   - States: IDLE, BUSY, DONE.
//   - Edge k, IDLE or DONE, start=1: latch A=a, B=sub?~b:b, C=sub?1:cin; idx=0; go to BUSY.
//   - BUSY, each edge: add chunk idx of A, B and carry C; write that chunk into the
//     internal partial result; C <= chunk carry; idx++.
//   - Edge k+NCHUNK (last chunk): copy the full result to sum, set cout and overflow, go to DONE.
//   - done=1 during exactly one cycle (k+NCHUNK .. k+NCHUNK+1); then IDLE unless start=1.
//   - Latency: start accepted at edge k -> done visible after edge k+NCHUNK.
//     Back-to-back starts give one result per NCHUNK+1 cycles.
//   - start while BUSY: ignored (no queueing); a, b, cin, sub may change freely during BUSY.
//   - start in DONE: accepted as in IDLE; done still pulses that cycle with the old result.
//   - sum/cout/overflow change only at the completion edge. The partial result is not visible.
//   - Arithmetic is modulo 2^WIDTH. overflow uses the carry into bit WIDTH-1 from the last chunk.
//   - NCHUNK==1 degenerates to a one-cycle BUSY, same protocol.
// TESTING
//   1. WIDTH=4,CHUNK=1: a=0110,b=0011,cin=0,add -> after 4 cycles done, sum=1001, cout=0, overflow=1
//   2. WIDTH=4,CHUNK=1: a=1111,b=0001,cin=1,add -> sum=0001, cout=1, overflow=0
//   3. Default: a=32'hFFFF_FFFF,b=1,cin=0 -> done exactly 4 cycles after start edge,
//      sum=0, cout=1, overflow=0; busy high for cycles 1-4
//   4. Default sub: a=5,b=7 -> sum=32'hFFFF_FFFE, cout=0; a=32'h8000_0000,b=1 -> sum=32'h7FFF_FFFF,
//      cout=1, overflow=1
//   5. start pulsed and operands changed during BUSY -> ignored; result matches the first
//      operands; start held high in DONE -> new op begins, done pulses once per op
//   6. rst asserted async mid-BUSY (idx=2) -> busy/done/sum/cout/overflow=0 immediately;
//      a new start after release completes correctly

Source files
------------

// File: rtl/add_seq.sv
// add_seq: multi-cycle adder/subtractor that adds CHUNK bits per clock, LSB chunk first
// Ports:
//   clk              rising-edge clock
//   rst              asynchronous active-high reset
//   start_i          request, accepted in IDLE or DONE, ignored in BUSY
//   sub_i            0: a+b+cin, 1: a-b (cin ignored)
//   a_i, b_i, cin_i  operands, latched on an accepted start
//   busy_o           high while the chunks are being added
//   done_o           one-cycle pulse when a new result is presented
//   sum_o, cout_o    result and carry out of the MSB (sub: 1 = no borrow), held until next completion
//   overflow_o       signed overflow of the last completed operation
module add_seq #(
   parameter int WIDTH = 32,
   parameter int CHUNK = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_i,
   input  logic             sub_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic             cin_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [WIDTH-1:0] sum_o,
   output logic             cout_o,
   output logic             overflow_o
);
   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int IW = NCHUNK > 1 ? $clog2(NCHUNK) : 1;
   localparam logic [IW-1:0] LAST = IW'(NCHUNK - 1);
   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
   state_t state_q, state_d;
   logic [IW-1:0] idx_q, idx_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d, part_q, part_d, part_upd, sum_q, sum_d;
   logic c_q, c_d, cout_q, cout_d, ovf_q, ovf_d;
   logic [CHUNK-1:0] a_ch, b_ch;
   logic [CHUNK:0] ch_sum;
   logic accept, in_busy, finish;

   always_comb begin
      a_ch = a_q[int'(idx_q) * CHUNK +: CHUNK];
      b_ch = b_q[int'(idx_q) * CHUNK +: CHUNK];
      ch_sum = {1'b0, a_ch} + {1'b0, b_ch} + {{CHUNK{1'b0}}, c_q};
      part_upd = part_q;
      part_upd[int'(idx_q) * CHUNK +: CHUNK] = ch_sum[CHUNK-1:0];
      accept = start_i && state_q != BUSY;
      in_busy = state_q == BUSY;
      finish = in_busy && idx_q == LAST;
      state_d = accept ? BUSY : finish ? DONE : in_busy ? BUSY : IDLE;
      idx_d = accept ? '0 : in_busy ? idx_q + 1'b1 : idx_q;
      a_d = accept ? a_i : a_q;
      // subtraction is a + ~b + 1, so the inversion and the forced carry are latched up front
      b_d = accept ? (sub_i ? ~b_i : b_i) : b_q;
      c_d = accept ? (sub_i | cin_i) : in_busy ? ch_sum[CHUNK] : c_q;
      part_d = in_busy ? part_upd : part_q;
      sum_d = finish ? part_upd : sum_q;
      cout_d = finish ? ch_sum[CHUNK] : cout_q;
      // carry into the MSB is recovered from the MSB sum bit: s = a ^ b ^ cin
      ovf_d = finish ? ch_sum[CHUNK] ^ (a_ch[CHUNK-1] ^ b_ch[CHUNK-1] ^ ch_sum[CHUNK-1]) : ovf_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         idx_q <= '0;
         a_q <= '0;
         b_q <= '0;
         c_q <= 1'b0;
         part_q <= '0;
         sum_q <= '0;
         cout_q <= 1'b0;
         ovf_q <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q <= idx_d;
         a_q <= a_d;
         b_q <= b_d;
         c_q <= c_d;
         part_q <= part_d;
         sum_q <= sum_d;
         cout_q <= cout_d;
         ovf_q <= ovf_d;
      end
   end

   assign busy_o = state_q == BUSY;
   assign done_o = state_q == DONE;
   assign sum_o = sum_q;
   assign cout_o = cout_q;
   assign overflow_o = ovf_q;
endmodule
